// File: rtl/lfsr_stream.sv
// Fibonacci LFSR random source: one bit per enabled clock, OUT_W-bit words on a valid/ready stream.
// Optional build macro LFSR_LOCKUP_GUARD_EN keeps the register out of the all-zero lock-up state.
module lfsr_stream #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hBEEF,
  parameter int unsigned      OUT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             reseed_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int unsigned     CntW    = $clog2(OUT_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OUT_W - 1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;

  logic             feedback;
  logic             hold;
  logic             shift;
  logic [WIDTH-1:0] shift_val;
  logic [WIDTH-1:0] seed_val;

  assign feedback = ^(state_q & TAPS);
  // A pending word blocks shifting until it is taken.
  assign hold     = valid_q & ~out_ready_i;
  assign shift    = enable_i & ~reseed_i & ~hold;

`ifdef LFSR_LOCKUP_GUARD_EN
  assign shift_val = (state_q == '0) ? SEED : {state_q[WIDTH-2:0], feedback};
  assign seed_val  = (seed_i == '0) ? SEED : seed_i;
`else
  assign shift_val = {state_q[WIDTH-2:0], feedback};
  assign seed_val  = seed_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (reseed_i) begin
      // Reseed discards any pending word, even one being accepted this cycle.
      state_d = seed_val;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (shift) begin
      state_d = shift_val;
      if (cnt_q == CntLast) begin
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + CntW'(1);
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q & ~out_ready_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign out_data_o  = state_q[OUT_W-1:0];
  assign out_valid_o = valid_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Randomised bench for lfsr_stream: a word-counting LFSR model plus directed scenarios,
// and a small 8-bit single-bit-word instance checked for its full period.
module tb_lfsr_stream;

  localparam int unsigned AW    = 16;
  localparam int unsigned ATAPS = 32'hB400;
  localparam int unsigned ASEED = 32'hBEEF;
  localparam int unsigned AOUT  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable_a, reseed_a, ready_a;
  logic [15:0]   seed_a;
  logic [3:0]    data_a;
  logic          valid_a;
  logic          enable_b, reseed_b, ready_b;
  logic [7:0]    seed_b;
  logic [0:0]    data_b;
  logic          valid_b;

  int n_vec = 0;
  int n_err = 0;

  // Model of instance A: current state, shifts since seeding, words consumed since seeding.
  int unsigned m_state;
  int          m_n;
  int          m_cons;

  always #5 clk = ~clk;

  lfsr_stream dut_a (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable_a),
    .reseed_i   (reseed_a),
    .seed_i     (seed_a),
    .out_data_o (data_a),
    .out_valid_o(valid_a),
    .out_ready_i(ready_a)
  );

  lfsr_stream #(
    .WIDTH(8),
    .TAPS (8'hB8),
    .SEED (8'h01),
    .OUT_W(1)
  ) dut_b (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable_b),
    .reseed_i   (reseed_b),
    .seed_i     (seed_b),
    .out_data_o (data_b),
    .out_valid_o(valid_b),
    .out_ready_i(ready_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned s, input int unsigned w,
                                            input int unsigned taps, input int unsigned seed);
    int unsigned p;
    int unsigned mask;
    p = 0;
`ifdef LFSR_LOCKUP_GUARD_EN
    if (s == 0) return seed;
`endif
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    for (int unsigned i = 0; i < w; i++)
      if ((((taps >> i) & 1) != 0) && (((s >> i) & 1) != 0)) p ^= 1;
    return ((s << 1) & mask) | p;
  endfunction

  function automatic bit model_valid();
    return (m_n / AOUT) > m_cons;
  endfunction

  task automatic model_reset();
    m_state = ASEED;
    m_n     = 0;
    m_cons  = 0;
  endtask

  task automatic model_edge();
    bit v;
    if (reseed_a) begin
`ifdef LFSR_LOCKUP_GUARD_EN
      m_state = (seed_a == 0) ? ASEED : 32'(seed_a);
`else
      m_state = 32'(seed_a);
`endif
      m_n    = 0;
      m_cons = 0;
    end else begin
      v = model_valid();
      if (v && ready_a) m_cons++;
      if (enable_a && !(v && !ready_a)) begin
        m_state = lfsr_next(m_state, AW, ATAPS, ASEED);
        m_n++;
      end
    end
  endtask

  // Inputs are changed at negedge; the model follows each posedge, outputs are checked at negedge.
  task automatic step_a();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("valid_a", 32'(valid_a), 32'(model_valid()));
    check("data_a", 32'(data_a), m_state & 32'hF);
  endtask

  initial begin
    int last;
    int found;
    int unsigned mb;

    rst_n    = 1'b0;
    enable_a = 1'b0; reseed_a = 1'b0; ready_a = 1'b1; seed_a = '0;
    enable_b = 1'b0; reseed_b = 1'b0; ready_b = 1'b1; seed_b = '0;
    model_reset();
    @(negedge clk);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_data", 32'(data_a), 32'hF);
    check("rst_state", 32'(dut_a.state_q), 32'hBEEF);

    // Test 1: first word after four enabled cycles.
    rst_n = 1'b1; enable_a = 1'b1;
    step_a(); check("t1_s1", 32'(dut_a.state_q), 32'h7DDE);
    step_a(); check("t1_s2", 32'(dut_a.state_q), 32'hFBBD);
    step_a(); check("t1_s3", 32'(dut_a.state_q), 32'hF77B);
    check("t1_novalid", 32'(valid_a), 32'd0);
    ready_a = 1'b0;
    step_a();
    check("t1_valid", 32'(valid_a), 32'd1);
    check("t1_word", 32'(data_a), 32'h6);
    check("t1_state", 32'(dut_a.state_q), 32'hEEF6);

    // Test 2: stall for ten cycles, then next word four cycles after the accept.
    for (int i = 0; i < 10; i++) begin
      step_a();
      check("t2_hold_state", 32'(dut_a.state_q), 32'hEEF6);
      check("t2_hold_word", 32'(data_a), 32'h6);
      check("t2_hold_valid", 32'(valid_a), 32'd1);
    end
    ready_a = 1'b1;
    found = -1;
    for (int i = 1; i <= 8 && found < 0; i++) begin
      step_a();
      if (valid_a) found = i;
    end
    check("t2_latency", 32'(found), 32'd4);

    // Test 3: enable toggling, words every eight cycles starting again from the seed.
    reseed_a = 1'b1; seed_a = 16'hBEEF;
    step_a();
    reseed_a = 1'b0;
    last = -1;
    for (int i = 0; i < 40; i++) begin
      enable_a = (i % 2 == 0);
      step_a();
      if (valid_a) begin
        if (last < 0) check("t3_first_word", 32'(data_a), 32'h6);
        else check("t3_spacing", 32'(i - last), 32'd8);
        last = i;
      end
    end

    // Test 4: reseed wins over an accept of a pending word.
    enable_a = 1'b1; ready_a = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step_a();
      found = valid_a;
    end
    check("t4_pending", 32'(found), 32'd1);
    ready_a = 1'b1; reseed_a = 1'b1; seed_a = 16'hBEEF;
    step_a();
    reseed_a = 1'b0;
    check("t4_valid_drop", 32'(valid_a), 32'd0);
    check("t4_cnt", 32'(dut_a.cnt_q), 32'd0);
    for (int i = 0; i < 4; i++) step_a();
    check("t4_word", 32'(data_a), 32'h6);

    // Test 5: zero seed.
    reseed_a = 1'b1; seed_a = 16'h0000;
    step_a();
    reseed_a = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
    check("t5_state", 32'(dut_a.state_q), 32'hBEEF);
`else
    check("t5_state", 32'(dut_a.state_q), 32'h0000);
`endif
    for (int i = 0; i < 12; i++) step_a();

    // Randomised traffic with occasional reseeds, some of them to zero.
    for (int i = 0; i < 3000; i++) begin
      enable_a = ($urandom_range(0, 3) != 0);
      ready_a  = ($urandom_range(0, 1) != 0);
      reseed_a = ($urandom_range(0, 63) == 0);
      seed_a   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      step_a();
    end

    // Test 6: async reset mid-word.
    enable_a = 1'b1; ready_a = 1'b1; reseed_a = 1'b1; seed_a = 16'h1234;
    step_a();
    reseed_a = 1'b0;
    step_a();
    step_a();
    check("t6_cnt", 32'(dut_a.cnt_q), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(valid_a), 32'd0);
    check("t6_async_state", 32'(dut_a.state_q), 32'hBEEF);
    check("t6_async_data", 32'(data_a), 32'hF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    found = -1;
    for (int i = 1; i <= 8 && found < 0; i++) begin
      step_a();
      if (valid_a) found = i;
    end
    check("t6_latency", 32'(found), 32'd4);
    check("t6_word", 32'(data_a), 32'h6);

    // 8-bit instance with one-bit words: full 255-step period, never zero.
    enable_a = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; enable_b = 1'b1; ready_b = 1'b1;
    mb = 32'h01;
    for (int i = 0; i < 520; i++) begin
      @(posedge clk);
      mb = lfsr_next(mb, 8, 32'hB8, 32'h01);
      @(negedge clk);
      check("b_valid", 32'(valid_b), 32'd1);
      check("b_data", 32'(data_b), mb & 32'h1);
      check("b_nonzero", 32'(dut_b.state_q != 8'h00), 32'd1);
      if (i == 254 || i == 509) check("b_period", 32'(dut_b.state_q), 32'h01);
      else if (i < 254) check("b_no_early_repeat", 32'(dut_b.state_q == 8'h01), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
